// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1011 detection path: serializer FSM states,
// detector FSM states, idle level default and a width helper.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Moore 1011 detector states, named by the suffix matched so far
    typedef enum logic [2:0] {
        DET_S0    = 3'd0,
        DET_S1    = 3'd1,
        DET_S10   = 3'd2,
        DET_S101  = 3'd3,
        DET_S1011 = 3'd4
    } det_state_t;

    localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 1011 detector: takes WIDTH-bit words
// over valid/ready and emits one bit per clock on w, gapless back-to-back.
module bit_serializer
    import seq_det_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
    input  logic             Clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             w_valid,
    output logic             last_bit
);

    localparam int CNT_W = clog2(WIDTH);

    ser_state_t       state;
    ser_state_t       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts bits still to come after the one on w, so cnt==0 marks the
    // last bit and is the only busy cycle in which a new word can be taken.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        w          = IDLE_LEVEL;
        w_valid    = 1'b0;
        last_bit   = 1'b0;
        load_ready = 1'b0;
        accept     = 1'b0;

        if (state == ST_SHIFT) begin
            w        = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            w_valid  = 1'b1;
            last_bit = (cnt == '0);
        end
        load_ready = (state == ST_IDLE) || last_bit;
        accept     = load_valid && load_ready;

        if (accept) begin
            shreg_nxt = load_data;
            cnt_nxt   = CNT_W'(WIDTH - 1);
            state_nxt = ST_SHIFT;
        end else if (last_bit) begin
            state_nxt = ST_IDLE;
        end else if (state == ST_SHIFT) begin
            shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg[WIDTH-1:1]};
            cnt_nxt   = cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one
// stimulus stream and are checked every cycle against a bit-queue model.
module tb_bit_serializer;

    localparam int WIDTH = 8;

    logic       Clock = 1'b0;
    logic       resetn;
    logic [7:0] load_data;
    logic       load_valid;

    logic ready_m, w_m, wv_m, lb_m;
    logic ready_l, w_l, wv_l, lb_l;

    int checks   = 0;
    int failures = 0;

    bit q_msb[$];
    bit q_lsb[$];
    bit model_acc;

    logic [31:0] cap_m, cap_l, cap_lb;
    int          cap_valid;

    always #5 Clock = ~Clock;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .Clock      (Clock),
        .resetn     (resetn),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .w          (w_m),
        .w_valid    (wv_m),
        .last_bit   (lb_m)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .Clock      (Clock),
        .resetn     (resetn),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .w          (w_l),
        .w_valid    (wv_l),
        .last_bit   (lb_l)
    );

    function automatic bit model_ready();
        return q_msb.size() <= 1;
    endfunction

    // Model: each queue holds the bits still to appear on w, head = current bit
    always @(posedge Clock) begin
        if (resetn) begin
            model_acc = load_valid && model_ready();
            if (q_msb.size() > 0) begin
                void'(q_msb.pop_front());
                void'(q_lsb.pop_front());
            end
            if (model_acc) begin
                for (int i = 0; i < WIDTH; i++) begin
                    q_msb.push_back(load_data[WIDTH-1-i]);
                    q_lsb.push_back(load_data[i]);
                end
            end
        end
    end

    always @(negedge resetn) begin
        q_msb.delete();
        q_lsb.delete();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge Clock) begin
        checkOutput("w_msb",      32'(w_m),     (q_msb.size() == 0) ? 32'd0 : 32'(q_msb[0]));
        checkOutput("w_lsb",      32'(w_l),     (q_lsb.size() == 0) ? 32'd0 : 32'(q_lsb[0]));
        checkOutput("wvalid_msb", 32'(wv_m),    32'(q_msb.size() != 0));
        checkOutput("wvalid_lsb", 32'(wv_l),    32'(q_lsb.size() != 0));
        checkOutput("last_msb",   32'(lb_m),    32'(q_msb.size() == 1));
        checkOutput("last_lsb",   32'(lb_l),    32'(q_lsb.size() == 1));
        checkOutput("ready_msb",  32'(ready_m), 32'(q_msb.size() <= 1));
        checkOutput("ready_lsb",  32'(ready_l), 32'(q_lsb.size() <= 1));
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic applyStimulus(input logic [7:0] word);
        bit acc;
        bit done;
        done       = 1'b0;
        load_data  = word;
        load_valid = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge Clock);
            acc = model_ready();
            @(posedge Clock);
            #1;
            if (acc) done = 1'b1;
        end
        load_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL load_timeout word %0h not accepted within 64 cycles", word);
        end
    endtask

    task automatic captureBits(input int n, output logic [31:0] bits_m,
                               output logic [31:0] bits_l, output logic [31:0] lasts,
                               output int valid_cnt);
        bits_m    = '0;
        bits_l    = '0;
        lasts     = '0;
        valid_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            bits_m = {bits_m[30:0], w_m};
            bits_l = {bits_l[30:0], w_l};
            lasts  = {lasts[30:0], lb_m};
            if (wv_m) valid_cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        load_valid = 1'b0;
        load_data  = 8'h00;
        resetn     = 1'b1;
        #1;
        resetn     = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hFF;

        repeat (3) begin
            @(negedge Clock);
            checkOutput("rst_w",      32'(w_m),     32'd0);
            checkOutput("rst_wvalid", 32'(wv_m),    32'd0);
            checkOutput("rst_ready",  32'(ready_m), 32'd1);
        end
        @(posedge Clock);
        #1;
        load_valid = 1'b0;
        resetn     = 1'b1;
        @(negedge Clock);
        checkOutput("rst_noload", 32'(wv_m), 32'd0);
        @(posedge Clock);
        #1;

        // Single word, both bit orders
        applyStimulus(8'hB0);
        captureBits(8, cap_m, cap_l, cap_lb, cap_valid);
        checkOutput("single_msb_stream", cap_m, 32'h0000_00B0);
        checkOutput("single_lsb_stream", cap_l, 32'h0000_000D);
        checkOutput("single_last",       cap_lb, 32'h0000_0001);
        checkOutput("single_valid_cnt",  32'(cap_valid), 32'd8);
        @(negedge Clock);
        checkOutput("single_idle_w",      32'(w_m),  32'd0);
        checkOutput("single_idle_wvalid", 32'(wv_m), 32'd0);
        @(posedge Clock);
        #1;

        applyStimulus(8'h0D);
        captureBits(8, cap_m, cap_l, cap_lb, cap_valid);
        checkOutput("lsb_first_stream", cap_l, 32'h0000_00B0);
        checkOutput("lsb_msb_stream",   cap_m, 32'h0000_000D);
        @(posedge Clock);
        #1;

        // Back-to-back across the word boundary
        applyStimulus(8'h05);
        fork
            applyStimulus(8'hB0);
            captureBits(16, cap_m, cap_l, cap_lb, cap_valid);
        join
        checkOutput("b2b_msb_stream", cap_m, 32'h0000_05B0);
        checkOutput("b2b_lsb_stream", cap_l, 32'h0000_A00D);
        checkOutput("b2b_last",       cap_lb, 32'h0000_0101);
        checkOutput("b2b_valid_cnt",  32'(cap_valid), 32'd16);
        @(posedge Clock);
        #1;

        // Busy rejection: valid pulsed during bits 2..5, dropped before last bit
        applyStimulus(8'hB0);
        fork
            captureBits(8, cap_m, cap_l, cap_lb, cap_valid);
            begin
                @(posedge Clock);
                #1;
                load_data  = 8'hFF;
                load_valid = 1'b1;
                repeat (4) @(posedge Clock);
                #1;
                load_valid = 1'b0;
            end
        join
        checkOutput("busy_msb_stream", cap_m, 32'h0000_00B0);
        @(negedge Clock);
        checkOutput("busy_not_loaded", 32'(wv_m), 32'd0);
        @(posedge Clock);
        #1;

        // Asynchronous reset after the third bit of 8'hFF
        applyStimulus(8'hFF);
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_w",      32'(w_m),     32'd0);
        checkOutput("midrst_wvalid", 32'(wv_m),    32'd0);
        checkOutput("midrst_ready",  32'(ready_m), 32'd1);
        @(posedge Clock);
        #1;
        resetn = 1'b1;
        applyStimulus(8'hB0);
        captureBits(8, cap_m, cap_l, cap_lb, cap_valid);
        checkOutput("postrst_msb_stream", cap_m, 32'h0000_00B0);
        checkOutput("postrst_lsb_stream", cap_l, 32'h0000_000D);

        // Randomized traffic, checked by the per-cycle compare process
        repeat (400) begin
            @(posedge Clock);
            #1;
            load_valid = ($urandom % 4) != 0;
            load_data  = 8'($urandom);
        end
        @(posedge Clock);
        #1;
        load_valid = 1'b0;
        repeat (12) @(posedge Clock);
        @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
